boot_loader: RTL

- Byte-stream program loader that fills instruction and data memories of the monocicle core, then releases it from reset.
- Host side: valid/ready byte interface. Memory side: one 32-bit instruction-word write port and one byte write port to byte-addressed data memory.
- Drives `core_rst` to hold the core until a RUN command arrives; replaces $readmem-style preloading in system-level runs.

---
 rtl/boot_loader.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Byte-stream program loader: parses CMD/LEN/ADR/payload/CSUM frames, writes
// instruction words and data bytes, and holds the core in reset until RUN.
module boot_loader #(
    parameter int INST_AW = 5,
    parameter int DATA_AW = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               inst_we,
    output logic [INST_AW-1:0] inst_addr,
    output logic [31:0]        inst_wdata,
    output logic               data_we,
    output logic [DATA_AW-1:0] data_addr,
    output logic [7:0]         data_wdata,
    output logic               core_rst,
    output logic               err
);

    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, ADR0, ADR1, PAYLOAD, CSUM, RUN
    } state_t;

    state_t             state_q, state_d;
    logic               is_inst_q, is_inst_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        addr_q, addr_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [23:0]        asm_q, asm_d;
    logic [7:0]         csum_q, csum_d;
    logic               rx_ready_q, rx_ready_d;
    logic               inst_we_q, inst_we_d;
    logic [INST_AW-1:0] inst_addr_q, inst_addr_d;
    logic [31:0]        inst_wdata_q, inst_wdata_d;
    logic               data_we_q, data_we_d;
    logic [DATA_AW-1:0] data_addr_q, data_addr_d;
    logic [7:0]         data_wdata_q, data_wdata_d;
    logic               core_rst_q, core_rst_d;
    logic               err_q, err_d;
    logic               accept;

    assign accept = rx_valid & rx_ready_q;

    always_comb begin
        state_d      = state_q;
        is_inst_d    = is_inst_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        csum_d       = csum_q;
        inst_we_d    = 1'b0;
        inst_addr_d  = inst_addr_q;
        inst_wdata_d = inst_wdata_q;
        data_we_d    = 1'b0;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        err_d        = err_q;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == 8'h01 || rx_data == 8'h02) begin
                        is_inst_d = (rx_data == 8'h01);
                        csum_d    = '0;
                        state_d   = LEN0;
                    end else if (rx_data == 8'h03) begin
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                LEN0: begin
                    cnt_d[7:0] = rx_data;
                    csum_d     = csum_q ^ rx_data;
                    state_d    = LEN1;
                end
                LEN1: begin
                    cnt_d[15:8] = rx_data;
                    csum_d      = csum_q ^ rx_data;
                    state_d     = ADR0;
                end
                ADR0: begin
                    addr_d[7:0] = rx_data;
                    csum_d      = csum_q ^ rx_data;
                    state_d     = ADR1;
                end
                ADR1: begin
                    addr_d[15:8] = rx_data;
                    csum_d       = csum_q ^ rx_data;
                    byte_idx_d   = '0;
                    state_d      = (cnt_q == 16'd0) ? CSUM : PAYLOAD;
                end
                PAYLOAD: begin
                    csum_d = csum_q ^ rx_data;
                    if (is_inst_q) begin
                        // Little-endian assembly: the 4th byte lands in [31:24].
                        asm_d      = {rx_data, asm_q[23:8]};
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            inst_we_d    = 1'b1;
                            inst_addr_d  = addr_q[INST_AW-1:0];
                            inst_wdata_d = {rx_data, asm_q};
                            addr_d       = addr_q + 16'd1;
                            cnt_d        = cnt_q - 16'd1;
                            if (cnt_q == 16'd1) begin
                                state_d = CSUM;
                            end
                        end
                    end else begin
                        data_we_d    = 1'b1;
                        data_addr_d  = addr_q[DATA_AW-1:0];
                        data_wdata_d = rx_data;
                        addr_d       = addr_q + 16'd1;
                        cnt_d        = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_d = CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (rx_data != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        rx_ready_d = (state_d != RUN);
        core_rst_d = (state_d != RUN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            is_inst_q    <= 1'b0;
            cnt_q        <= '0;
            addr_q       <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            csum_q       <= '0;
            rx_ready_q   <= 1'b0;
            inst_we_q    <= 1'b0;
            inst_addr_q  <= '0;
            inst_wdata_q <= '0;
            data_we_q    <= 1'b0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_inst_q    <= is_inst_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            csum_q       <= csum_d;
            rx_ready_q   <= rx_ready_d;
            inst_we_q    <= inst_we_d;
            inst_addr_q  <= inst_addr_d;
            inst_wdata_q <= inst_wdata_d;
            data_we_q    <= data_we_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            core_rst_q   <= core_rst_d;
            err_q        <= err_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign inst_we    = inst_we_q;
    assign inst_addr  = inst_addr_q;
    assign inst_wdata = inst_wdata_q;
    assign data_we    = data_we_q;
    assign data_addr  = data_addr_q;
    assign data_wdata = data_wdata_q;
    assign core_rst   = core_rst_q;
    assign err        = err_q;

endmodule
